// File: rtl/calc_result_formatter_pkg.sv
// Shared calculator definitions: ASCII codes, operator codes and result-formatter states.
package calc_result_formatter_pkg;

  localparam logic [7:0] ASCII_LF    = 8'd10;
  localparam logic [7:0] ASCII_BS    = 8'd8;
  localparam logic [7:0] ASCII_ESC   = 8'd27;
  localparam logic [7:0] ASCII_0     = 8'd48;
  localparam logic [7:0] ASCII_MINUS = 8'd45;
  localparam logic [7:0] ASCII_E     = 8'd69;
  localparam logic [7:0] ASCII_R     = 8'd114;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_POW = 3'd4
  } calc_op_t;

  typedef enum logic [2:0] {
    FMT_IDLE    = 3'd0,
    FMT_CONVERT = 3'd1,
    FMT_SIGN    = 3'd2,
    FMT_DIGITS  = 3'd3,
    FMT_ERR     = 3'd4,
    FMT_TERM    = 3'd5,
    FMT_FIN     = 3'd6
  } fmt_state_t;

  // Decimal digits needed for a DATA_W-bit magnitude: ceil(data_w * log10(2)).
  function automatic int calc_max_dig(input int data_w);
    return (data_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/calc_result_formatter_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, DATA_W cycles after start.
module calc_result_formatter_bin2bcd_seq
  import calc_result_formatter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_DIG = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   start,
  input  logic [DATA_W-1:0]      bin,
  output logic [MAX_DIG*4-1:0]   bcd,
  output logic                   done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]    shift_r;
  logic [MAX_DIG*4-1:0] bcd_r;
  logic [MAX_DIG*4-1:0] adj_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 active_r;

  // Add-3 correction of every BCD digit that is 5 or more before the next shift.
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5) begin
        adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
      end else begin
        adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
      end
    end
  end

  // Load on start, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r  <= '0;
      bcd_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
    end else if (clear) begin
      shift_r  <= '0;
      bcd_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
    end else if (start) begin
      shift_r  <= bin;
      bcd_r    <= '0;
      cnt_r    <= CNT_W'(DATA_W);
      active_r <= 1'b1;
    end else if (cnt_r != '0) begin
      bcd_r    <= {adj_s[MAX_DIG*4-2:0], shift_r[DATA_W-1]};
      shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
      cnt_r    <= cnt_r - 1'b1;
    end
  end

  assign bcd  = bcd_r;
  assign done = active_r && (cnt_r == '0);

endmodule

// File: rtl/calc_result_formatter.sv
// Calculator result path: signed result or error in, ASCII character stream out over valid/ready.
module calc_result_formatter
  import calc_result_formatter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int EMIT_NEWLINE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] res_value,
  input  logic              res_error,
  input  logic              res_valid,
  input  logic              clear_req,
  output logic [7:0]        char_ascii,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done_pulse
);

  localparam int MAX_DIG = calc_max_dig(DATA_W);
  localparam int IDX_W   = (MAX_DIG > 1) ? $clog2(MAX_DIG) : 1;

  localparam logic [2:0] S_IDLE    = FMT_IDLE;
  localparam logic [2:0] S_CONVERT = FMT_CONVERT;
  localparam logic [2:0] S_SIGN    = FMT_SIGN;
  localparam logic [2:0] S_DIGITS  = FMT_DIGITS;
  localparam logic [2:0] S_ERR     = FMT_ERR;
  localparam logic [2:0] S_TERM    = FMT_TERM;
  localparam logic [2:0] S_FIN     = FMT_FIN;

  logic [2:0]           state_r;
  logic                 neg_r;
  logic                 lf_sent_r;
  logic [1:0]           err_idx_r;
  logic [IDX_W-1:0]     dig_idx_r;
  logic [7:0]           char_ascii_r;
  logic                 char_valid_r;
  logic                 busy_r;
  logic                 done_pulse_r;

  logic [DATA_W-1:0]    mag_s;
  logic                 conv_start_s;
  logic                 conv_done_s;
  logic [MAX_DIG*4-1:0] bcd_s;
  logic [IDX_W-1:0]     msd_s;
  logic [7:0]           digit_char_s;
  logic [7:0]           err_char_s;
  logic                 slot_free_s;

  // Most negative input negates to itself, which is the correct unsigned magnitude.
  assign mag_s        = res_value[DATA_W-1] ? (~res_value + DATA_W'(1)) : res_value;
  assign conv_start_s = (state_r == S_IDLE) && res_valid && !res_error && !clear_req;
  assign digit_char_s = ASCII_0 + {4'd0, bcd_s[{dig_idx_r, 2'b00} +: 4]};
  assign err_char_s   = (err_idx_r == 2'd0) ? ASCII_E : ASCII_R;
  assign slot_free_s  = !char_valid_r || char_ready;

  calc_result_formatter_bin2bcd_seq #(
    .DATA_W  (DATA_W),
    .MAX_DIG (MAX_DIG)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .clear (clear_req),
    .start (conv_start_s),
    .bin   (mag_s),
    .bcd   (bcd_s),
    .done  (conv_done_s)
  );

  // Leading-zero suppression: index of the most significant non-zero digit (0 for value 0).
  always_comb begin
    msd_s = '0;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (bcd_s[i*4 +: 4] != 4'd0) begin
        msd_s = IDX_W'(i);
      end else begin
        msd_s = msd_s;
      end
    end
  end

  // Formatter FSM and output register; a new character loads on the same edge the old one is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      neg_r        <= 1'b0;
      lf_sent_r    <= 1'b0;
      err_idx_r    <= 2'd0;
      dig_idx_r    <= '0;
      char_ascii_r <= 8'd0;
      char_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_pulse_r <= 1'b0;
    end else if (clear_req) begin
      state_r      <= S_IDLE;
      neg_r        <= 1'b0;
      lf_sent_r    <= 1'b0;
      err_idx_r    <= 2'd0;
      dig_idx_r    <= '0;
      char_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_pulse_r <= 1'b0;
    end else begin
      done_pulse_r <= 1'b0;
      if (char_valid_r && char_ready) begin
        char_valid_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (res_valid) begin
            busy_r    <= 1'b1;
            lf_sent_r <= 1'b0;
            err_idx_r <= 2'd0;
            neg_r     <= res_value[DATA_W-1];
            state_r   <= res_error ? S_ERR : S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (conv_done_s) begin
            dig_idx_r <= msd_s;
            state_r   <= S_SIGN;
          end
        end
        S_SIGN: begin
          if (slot_free_s) begin
            char_valid_r <= 1'b1;
            if (neg_r) begin
              char_ascii_r <= ASCII_MINUS;
              state_r      <= S_DIGITS;
            end else begin
              char_ascii_r <= digit_char_s;
              dig_idx_r    <= dig_idx_r - 1'b1;
              state_r      <= (dig_idx_r == '0) ? S_TERM : S_DIGITS;
            end
          end
        end
        S_DIGITS: begin
          if (slot_free_s) begin
            char_valid_r <= 1'b1;
            char_ascii_r <= digit_char_s;
            dig_idx_r    <= dig_idx_r - 1'b1;
            state_r      <= (dig_idx_r == '0) ? S_TERM : S_DIGITS;
          end
        end
        S_ERR: begin
          if (slot_free_s) begin
            char_valid_r <= 1'b1;
            char_ascii_r <= err_char_s;
            err_idx_r    <= err_idx_r + 2'd1;
            state_r      <= (err_idx_r == 2'd2) ? S_TERM : S_ERR;
          end
        end
        S_TERM: begin
          if (slot_free_s) begin
            if ((EMIT_NEWLINE != 0) && !lf_sent_r) begin
              char_valid_r <= 1'b1;
              char_ascii_r <= ASCII_LF;
              lf_sent_r    <= 1'b1;
            end else begin
              busy_r       <= 1'b0;
              done_pulse_r <= 1'b1;
              state_r      <= S_FIN;
            end
          end
        end
        S_FIN: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r      <= S_IDLE;
          char_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign char_ascii = char_ascii_r;
  assign char_valid = char_valid_r;
  assign busy       = busy_r;
  assign done_pulse = done_pulse_r;

endmodule

// File: tb/tb_calc_result_formatter.sv
// Randomised self-checking bench: a string-level model of each result stream is checked every cycle.
module tb_calc_result_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] res_value = 32'd0;
  logic        res_error = 1'b0;
  logic        res_valid = 1'b0;
  logic        clear_req = 1'b0;
  logic        char_ready = 1'b1;
  logic [7:0]  char_ascii;
  logic        char_valid;
  logic        busy;
  logic        done_pulse;

  int n_cmp = 0;
  int n_err = 0;
  bit stall_en = 1'b0;

  string      exp_s = "";
  string      got_s = "";
  string      last_stream = "";
  int         pos = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         acc_cyc = 0;
  int         done_due = -1;
  int         first_seen = -1;
  int         last_lat = -1;
  int         streams_done = 0;
  bit         act = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_ascii = 8'd0;

  calc_result_formatter #(
    .DATA_W       (32),
    .EMIT_NEWLINE (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .res_value  (res_value),
    .res_error  (res_error),
    .res_valid  (res_valid),
    .clear_req  (clear_req),
    .char_ascii (char_ascii),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  // Expected text for one result: decimal with sign, or "Err", always followed by LF.
  function automatic string fmt_model(input logic [31:0] v, input bit e);
    longint sv;
    string  s;
    if (e) begin
      s = "Err";
    end else begin
      sv = longint'($signed(v));
      if (sv < 0) s = $sformatf("-%0d", -sv);
      else        s = $sformatf("%0d", sv);
    end
    return {s, "\n"};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got len %0d \"%s\", want len %0d \"%s\"", name, got.len(), got, want.len(), want);
    end
  endtask

  // Per-cycle monitor: compares outputs with the model, then advances the model across the edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_char_valid", 32'(char_valid), 32'd0);
      chk("rst_char_ascii", 32'(char_ascii), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done_pulse", 32'(done_pulse), 32'd0);
      act       = 1'b0;
      done_due  = -1;
      prev_hold = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(act));
      chk("done_pulse", 32'(done_pulse), 32'(cyc == done_due));
      if (act) begin
        if (cyc < first_cyc) chk("early_valid", 32'(char_valid), 32'd0);
        else if (cyc == first_cyc) chk("first_valid", 32'(char_valid), 32'd1);
        else if (!stall_en) chk("no_bubble", 32'(char_valid), 32'd1);
        if (prev_hold) begin
          chk("held_valid", 32'(char_valid), 32'd1);
          chk("held_ascii", 32'(char_ascii), 32'(prev_ascii));
        end
        if (char_valid && pos < exp_s.len()) begin
          chk("char", 32'(char_ascii), 32'(exp_s[pos]));
          if (first_seen < 0) begin
            first_seen = cyc;
            last_lat   = cyc - acc_cyc - 1;
          end
        end
      end else begin
        chk("idle_valid", 32'(char_valid), 32'd0);
      end
      prev_hold  = char_valid && !char_ready && !clear_req;
      prev_ascii = char_ascii;
      if (clear_req) begin
        act       = 1'b0;
        prev_hold = 1'b0;
      end else if (act) begin
        if (char_valid && char_ready) begin
          got_s = {got_s, string'(char_ascii)};
          pos++;
          if (pos >= exp_s.len()) begin
            act         = 1'b0;
            done_due    = cyc + 1;
            last_stream = got_s;
            streams_done++;
          end
        end
      end else if (res_valid && cyc != done_due) begin
        exp_s      = fmt_model(res_value, res_error);
        got_s      = "";
        pos        = 0;
        act        = 1'b1;
        acc_cyc    = cyc;
        first_seen = -1;
        first_cyc  = cyc + (res_error ? 2 : 35);
      end
    end
  end

  // Sink: always ready, or randomly stalling when stall_en is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      char_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done_pulse) && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic send(input logic [31:0] v, input bit e);
    res_value = v;
    res_error = e;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_stream(input int sd, input bit pulse_busy);
    int n = 0;
    while (streams_done == sd && n < 3000) begin
      if (pulse_busy && busy && $urandom_range(0, 2) == 0) begin
        res_value = $urandom;
        res_error = 1'($urandom_range(0, 1));
        res_valid = 1'b1;
      end
      tick();
      res_valid = 1'b0;
      n++;
    end
    chk("stream_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic run_one(input logic [31:0] v, input bit e, input string want, input int lat);
    int sd;
    wait_idle();
    sd = streams_done;
    send(v, e);
    wait_stream(sd, 1'b0);
    if (want.len() > 0) chk_str("stream", last_stream, want);
    if (lat >= 0) chk("first_char_latency", 32'(last_lat), 32'(lat));
  endtask

  initial begin
    int sd;
    logic [31:0] v;
    bit e;

    chk_str("model_12345", fmt_model(32'd12345, 1'b0), "12345\n");
    chk_str("model_min", fmt_model(32'h8000_0000, 1'b0), "-2147483648\n");
    chk_str("model_err", fmt_model(32'd99, 1'b1), "Err\n");

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", 32'(char_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    run_one(32'd12345, 1'b0, "12345\n", 34);
    run_one(32'hFFFF_FFF9, 1'b0, "-7\n", 34);
    run_one(32'd0, 1'b0, "0\n", 34);
    run_one(32'h8000_0000, 1'b0, "-2147483648\n", 34);
    run_one(32'h7FFF_FFFF, 1'b0, "2147483647\n", 34);
    run_one(32'd99, 1'b1, "Err\n", 1);

    // Stalled sink with requests arriving while busy.
    wait_idle();
    stall_en = 1'b1;
    sd = streams_done;
    send(32'd305, 1'b0);
    wait_stream(sd, 1'b1);
    chk_str("stall_305", last_stream, "305\n");
    stall_en = 1'b0;

    // Abort mid-digits; a simultaneous request must be ignored.
    wait_idle();
    sd = streams_done;
    send(32'd12345, 1'b0);
    for (int n = 0; n < 200 && !(act && pos >= 2); n++) tick();
    clear_req = 1'b1;
    res_value = 32'd5;
    res_valid = 1'b1;
    tick();
    clear_req = 1'b0;
    res_valid = 1'b0;
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_valid", 32'(char_valid), 32'd0);
    repeat (5) tick();
    chk("clear_no_done", 32'(streams_done), 32'(sd));
    run_one(32'd42, 1'b0, "42\n", 34);

    // Asynchronous reset in the middle of conversion.
    wait_idle();
    send(32'd77, 1'b0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    run_one(32'hFFFF_FECF, 1'b0, "-305\n", 34);

    for (int k = 0; k < 30; k++) begin
      wait_idle();
      stall_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       begin v = 32'($signed($urandom_range(0, 199998)) - 99999); e = 1'b0; end
        1:       begin v = $urandom; e = 1'b0; end
        2:       begin v = $urandom; e = 1'b1; end
        default: begin v = 32'($urandom_range(0, 9)); e = 1'b0; end
      endcase
      sd = streams_done;
      send(v, e);
      wait_stream(sd, stall_en);
    end
    stall_en = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
